// File: rtl/wb2ahb_pkg.sv
// Shared types for the Wishbone-to-AHB-Lite bridge.
// Transfer encodings, FSM states and constants.
package wb2ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/wb_sel_decoder.sv
// Wishbone byte-select decoder.
// Maps wb_sel onto an AHB size and byte offset.
module wb_sel_decoder
  import wb2ahb_pkg::*;
(
  input  logic [3:0] sel_i,
  output hsize_t     hsize_o,
  output logic [1:0] offset_o,
  output logic       illegal_o
);

  // Only naturally aligned byte, half and word lanes are legal
  always_comb begin
    hsize_o   = HSIZE_WORD;
    offset_o  = 2'd0;
    illegal_o = 1'b0;
    unique case (sel_i)
      4'b1111: begin
        hsize_o  = HSIZE_WORD;
        offset_o = 2'd0;
      end
      4'b0011: begin
        hsize_o  = HSIZE_HALF;
        offset_o = 2'd0;
      end
      4'b1100: begin
        hsize_o  = HSIZE_HALF;
        offset_o = 2'd2;
      end
      4'b0001: begin
        hsize_o  = HSIZE_BYTE;
        offset_o = 2'd0;
      end
      4'b0010: begin
        hsize_o  = HSIZE_BYTE;
        offset_o = 2'd1;
      end
      4'b0100: begin
        hsize_o  = HSIZE_BYTE;
        offset_o = 2'd2;
      end
      4'b1000: begin
        hsize_o  = HSIZE_BYTE;
        offset_o = 2'd3;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wishbone_to_ahb.sv
// Wishbone classic slave to AHB-Lite master bridge.
// Single non-pipelined transfers, every output registered.
module wishbone_to_ahb
  import wb2ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter logic [3:0]  HPROT_VALUE = 4'b0011
) (
  input  logic                  clk_core,
  input  logic                  rst_core,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [3:0]            wb_sel,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [31:0]           wb_dat_w,
  output logic [31:0]           wb_dat_r,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [31:0]           HWDATA,
  input  logic [31:0]           HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  state_t                state_q, state_d;
  htrans_t               htrans_q, htrans_d;
  hsize_t                hsize_q, hsize_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic                  hwrite_q, hwrite_d;
  logic [31:0]           hwdata_q, hwdata_d;
  logic [31:0]           dat_r_q, dat_r_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  abort_q, abort_d;

  hsize_t     dec_hsize;
  logic [1:0] dec_off;
  logic       dec_ill;
  logic       unused_adr;

  assign unused_adr = ^wb_adr[1:0];

  wb_sel_decoder u_dec (
    .sel_i     (wb_sel),
    .hsize_o   (dec_hsize),
    .offset_o  (dec_off),
    .illegal_o (dec_ill)
  );

  // Next state and next values of all registered outputs
  always_comb begin
    state_d  = state_q;
    htrans_d = htrans_q;
    hsize_d  = hsize_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    dat_r_d  = dat_r_q;
    abort_d  = abort_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (wb_cyc && wb_stb) begin
          if (dec_ill) begin
            err_d   = 1'b1;
            dat_r_d = '0;
            state_d = ST_RESP;
          end else begin
            haddr_d  = {wb_adr[ADDR_WIDTH-1:2],
                        dec_off};
            hsize_d  = dec_hsize;
            hwrite_d = wb_we;
            hwdata_d = wb_dat_w;
            htrans_d = HTRANS_NONSEQ;
            state_d  = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (!wb_cyc) abort_d = 1'b1;
        if (HREADY) begin
          htrans_d = HTRANS_IDLE;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        // An error's first cycle (HREADY low) just holds here
        if (!wb_cyc) abort_d = 1'b1;
        if (HREADY) begin
          state_d = ST_RESP;
          if (hwrite_q || HRESP) dat_r_d = '0;
          else                   dat_r_d = HRDATA;
          if (!abort_d) begin
            err_d = HRESP;
            ack_d = !HRESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q  <= ST_IDLE;
      htrans_q <= HTRANS_IDLE;
      hsize_q  <= HSIZE_BYTE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      dat_r_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      htrans_q <= htrans_d;
      hsize_q  <= hsize_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      dat_r_q  <= dat_r_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
    end
  end

  assign wb_dat_r  = dat_r_q;
  assign wb_ack    = ack_q;
  assign wb_err    = err_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VALUE;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_wishbone_to_ahb.sv
// Directed self-checking bench for wishbone_to_ahb.
// Slave side is driven cycle by cycle from the stimulus.
module tb_wishbone_to_ahb;

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic        wb_ack, wb_err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_core = ~clk_core;

  wishbone_to_ahb dut (
    .clk_core  (clk_core),
    .rst_core  (rst_core),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_sel    (wb_sel),
    .wb_adr    (wb_adr),
    .wb_dat_w  (wb_dat_w),
    .wb_dat_r  (wb_dat_r),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HMASTLOCK (HMASTLOCK),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // advance one edge, settle 1ns past it
  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic req(input logic we,
                     input logic [3:0] sel,
                     input logic [31:0] adr,
                     input logic [31:0] dw);
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_sel   = sel;
    wb_adr   = adr;
    wb_dat_w = dw;
  endtask

  task automatic drop();
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
  endtask

  initial begin
    rst_core = 1'b1;
    drop();
    wb_we    = 1'b0;
    wb_sel   = 4'h0;
    wb_adr   = '0;
    wb_dat_w = '0;
    HRDATA   = '0;
    HREADY   = 1'b1;
    HRESP    = 1'b0;
    tick();
    tick();
    rst_core = 1'b0;

    chk("rst_ack", 32'(wb_ack), 32'd0);
    chk("rst_err", 32'(wb_err), 32'd0);
    chk("rst_datr", wb_dat_r, 32'h0);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("hburst", 32'(HBURST), 32'd0);
    chk("hprot", 32'(HPROT), 32'h3);
    chk("hmastlock", 32'(HMASTLOCK), 32'd0);

    // word read, zero-wait
    req(1'b0, 4'b1111, 32'h100, 32'h0);
    HRDATA = 32'hDEADBEEF;
    tick();
    chk("rd_c1_htrans", 32'(HTRANS), 32'h2);
    chk("rd_c1_haddr", HADDR, 32'h100);
    chk("rd_c1_hsize", 32'(HSIZE), 32'h2);
    chk("rd_c1_hwrite", 32'(HWRITE), 32'h0);
    chk("rd_c1_ack", 32'(wb_ack), 32'h0);
    tick();
    chk("rd_c2_htrans", 32'(HTRANS), 32'h0);
    chk("rd_c2_ack", 32'(wb_ack), 32'h0);
    tick();
    chk("rd_c3_ack", 32'(wb_ack), 32'h1);
    chk("rd_c3_err", 32'(wb_err), 32'h0);
    chk("rd_c3_dat", wb_dat_r, 32'hDEADBEEF);
    drop();
    tick();
    chk("rd_c4_ack", 32'(wb_ack), 32'h0);

    // byte write, two data-phase wait states
    req(1'b1, 4'b0100, 32'h200, 32'h00AB0000);
    tick();
    chk("bw_c1_haddr", HADDR, 32'h202);
    chk("bw_c1_hsize", 32'(HSIZE), 32'h0);
    chk("bw_c1_hwrite", 32'(HWRITE), 32'h1);
    chk("bw_c1_htrans", 32'(HTRANS), 32'h2);
    tick();
    HREADY = 1'b0;
    chk("bw_c2_htrans", 32'(HTRANS), 32'h0);
    chk("bw_c2_hwdata", HWDATA, 32'h00AB0000);
    tick();
    chk("bw_c3_hwdata", HWDATA, 32'h00AB0000);
    chk("bw_c3_ack", 32'(wb_ack), 32'h0);
    tick();
    HREADY = 1'b1;
    chk("bw_c4_hwdata", HWDATA, 32'h00AB0000);
    chk("bw_c4_ack", 32'(wb_ack), 32'h0);
    tick();
    chk("bw_c5_ack", 32'(wb_ack), 32'h1);
    chk("bw_c5_dat", wb_dat_r, 32'h0);
    drop();
    tick();
    chk("bw_c6_ack", 32'(wb_ack), 32'h0);

    // halfword read, slave error
    req(1'b0, 4'b1100, 32'h300, 32'h0);
    tick();
    chk("he_c1_haddr", HADDR, 32'h302);
    chk("he_c1_hsize", 32'(HSIZE), 32'h1);
    tick();
    HREADY = 1'b0;
    HRESP  = 1'b1;
    chk("he_c2_htrans", 32'(HTRANS), 32'h0);
    tick();
    HREADY = 1'b1;
    chk("he_c3_htrans", 32'(HTRANS), 32'h0);
    chk("he_c3_err", 32'(wb_err), 32'h0);
    tick();
    HRESP = 1'b0;
    chk("he_c4_err", 32'(wb_err), 32'h1);
    chk("he_c4_ack", 32'(wb_ack), 32'h0);
    chk("he_c4_htrans", 32'(HTRANS), 32'h0);
    drop();
    tick();
    chk("he_c5_err", 32'(wb_err), 32'h0);

    // illegal byte select
    req(1'b0, 4'b0101, 32'h340, 32'h0);
    tick();
    chk("il_c1_err", 32'(wb_err), 32'h1);
    chk("il_c1_ack", 32'(wb_ack), 32'h0);
    chk("il_c1_htrans", 32'(HTRANS), 32'h0);
    drop();
    tick();
    chk("il_c2_err", 32'(wb_err), 32'h0);
    chk("il_c2_htrans", 32'(HTRANS), 32'h0);

    // abort during a stalled address phase
    req(1'b0, 4'b1111, 32'h400, 32'h0);
    HREADY = 1'b0;
    tick();
    chk("ab_c1_htrans", 32'(HTRANS), 32'h2);
    drop();
    tick();
    chk("ab_c2_htrans", 32'(HTRANS), 32'h2);
    chk("ab_c2_haddr", HADDR, 32'h400);
    HREADY = 1'b1;
    tick();
    chk("ab_c3_htrans", 32'(HTRANS), 32'h0);
    tick();
    chk("ab_c4_ack", 32'(wb_ack), 32'h0);
    chk("ab_c4_err", 32'(wb_err), 32'h0);
    tick();
    chk("ab_c5_ack", 32'(wb_ack), 32'h0);

    // read after the abort
    req(1'b0, 4'b1111, 32'h500, 32'h0);
    HRDATA = 32'h12345678;
    tick();
    chk("ar_c1_htrans", 32'(HTRANS), 32'h2);
    chk("ar_c1_haddr", HADDR, 32'h500);
    tick();
    tick();
    chk("ar_c3_ack", 32'(wb_ack), 32'h1);
    chk("ar_c3_dat", wb_dat_r, 32'h12345678);
    drop();
    tick();

    // reset while in the data phase
    req(1'b1, 4'b1111, 32'h600, 32'hCAFEF00D);
    tick();
    tick();
    HREADY = 1'b0;
    chk("rs_c2_hwdata", HWDATA, 32'hCAFEF00D);
    rst_core = 1'b1;
    tick();
    rst_core = 1'b0;
    drop();
    HREADY = 1'b1;
    chk("rs_htrans", 32'(HTRANS), 32'h0);
    chk("rs_haddr", HADDR, 32'h0);
    chk("rs_hwdata", HWDATA, 32'h0);
    chk("rs_hwrite", 32'(HWRITE), 32'h0);
    chk("rs_hsize", 32'(HSIZE), 32'h0);
    chk("rs_ack", 32'(wb_ack), 32'h0);
    tick();
    chk("rs_c2_ack", 32'(wb_ack), 32'h0);
    chk("rs_c2_htrans", 32'(HTRANS), 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
